sbox_share_ctrl: RTL
====================

Name: sbox_share_ctrl

Overview:
Sequencer and arbiter that time-shares a small bank of byte S-box lookups between two requesters: the round datapath (SubBytes on a 128-bit state) and the key schedule (SubWord on a 32-bit word). It accepts one job at a time through a valid/ready handshake. It feeds LANES bytes per cycle through LANES instances of sbox_LUT, reassembles the result and pulses a per-requester done. It sits between the round controller/key expansion and the S-box bank, so the cipher does not need 20 parallel S-boxes.

Parameters:
LANES, 4, bytes substituted per cycle; legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
st_valid  in  1  state SubBytes request.
st_ready  out  1  state request can be accepted this cycle.
st_in  in  128  state to substitute; byte k = st_in[127-8k -: 8], k = 0..15.
st_out  out  128  substituted state, same byte order.
st_done  out  1  one-cycle pulse; st_out is valid.
kw_valid  in  1  key-schedule SubWord request.
kw_ready  out  1  word request can be accepted this cycle.
kw_in  in  32  word to substitute; byte k = kw_in[31-8k -: 8], k = 0..3.
kw_out  out  32  substituted word.
kw_done  out  1  one-cycle pulse; kw_out is valid.
busy  out  1  high whenever FSM is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: st_out = 0, kw_out = 0, st_done = 0, kw_done = 0, busy = 0, FSM = IDLE, last_grant = ST.
- FSM states and transitions:
  - IDLE → RUN_ST on state acceptance.
  - IDLE → RUN_KW on word acceptance.
  - RUN_ST and RUN_KW → IDLE after the final beat.
- Ready rules:
  - st_ready and kw_ready are high only in IDLE and when rst = 0.
  - Both readies are combinational from FSM state and the arbiter result.
- Arbitration (IDLE only):
  - If exactly one valid is high, that requester is granted.
  - If both are high, grant the requester not in last_grant (round-robin). After reset, the first tie goes to KW.
  - Only the granted requester sees ready high in that cycle.
  - last_grant updates on every acceptance.
- Acceptance:
  - A request is accepted when valid & ready at a clock edge.
  - The input is latched into an internal buffer; later changes on st_in/kw_in are ignored.
  - valid may drop before acceptance with no effect.
- Beats:
  - Beat count B = 16/LANES for state jobs, 4/LANES for word jobs.
  - Beat j (0..B-1) substitutes bytes j*LANES .. j*LANES+LANES-1.
  - Each lane output is written into the corresponding byte of st_out/kw_out at the end of the beat.
  - The beat counter is log2(16) bits wide and clears on acceptance.
- Latency:
  - If accepted in cycle c, beats run in cycles c+1..c+B.
  - The done pulse is high in cycle c+B+1, and FSM is back in IDLE in that same cycle.
  - A new acceptance is possible in cycle c+B+1, so a back-to-back job has zero bubble beyond the done cycle.
  - With LANES=4: state latency 5 cycles, word latency 2 cycles. With LANES=1: 17 and 5 cycles.
- Output holding:
  - st_out changes only during RUN_ST; kw_out changes only during RUN_KW.
  - Each holds its last completed value indefinitely.
  - During a job, partially updated bytes are visible; consumers must use the done pulse.
- Done pulses: exactly one cycle long; never both high in the same cycle.
- Reset mid-operation: the job is aborted, outputs are cleared to 0, no done pulse is issued, and FSM returns to IDLE.
- Lane mux: lane l reads buffer byte j*LANES+l. Unused upper buffer bytes are don't-care in RUN_KW.

Decomposition:
- Shared package: FSM state encoding (IDLE, RUN_ST, RUN_KW), grant encoding (ST, KW), constants STATE_BYTES=16 and WORD_BYTES=4, and a beats(bytes, lanes) constant function.
- Sub-module: sbox_LUT, the existing byte S-box, instantiated LANES times inside a generate loop.
- No other sub-module; arbiter, FSM and byte mux live in sbox_share_ctrl.

Test Plan:
1. Basic state job, LANES=4: st_in = 00112233445566778899aabbccddeeff, accepted in cycle c → st_done high only in cycle c+5, st_out = 638293c31bfc33f5c4eeacea4bc12816, kw_out stays 0.
2. Basic word job: kw_in = cf4f3c09 → kw_done 2 cycles after acceptance, kw_out = 8a84eb01, st_out unchanged.
3. Simultaneous request after reset: st_valid and kw_valid rise in the same cycle.
   → KW is granted first and kw_done arrives.
   → ST is accepted in the kw_done cycle; its st_done follows 5 cycles later.
   → A second tie is granted to the side not granted last.
4. Reset mid-job: rst pulsed in the 3rd beat of a state job → next cycle busy = 0, st_out = 0, no st_done.
   → A subsequent job completes normally.
5. Input and handshake robustness:
   → Changing st_in to ffff…ff the cycle after acceptance still yields the vector-1 result.
   → st_valid held high through a job is not re-accepted until the done cycle.
6. LANES=1 and LANES=2 builds: repeat vectors 1 and 2.
   → LANES=1: latencies 17 and 5 cycles.
   → LANES=2: latencies 9 and 3 cycles.
   → Results are identical.

Source files
------------

// File: rtl/sbox_share_ctrl_pkg.sv
// Shared types and constants for the time-shared S-box sequencer.
// Imported by sbox_share_ctrl.
package sbox_share_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_ST = 2'd1,
        RUN_KW = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_ST = 1'b0,
        GRANT_KW = 1'b1
    } grant_e;

    localparam int STATE_BYTES = 16;
    localparam int WORD_BYTES  = 4;
    localparam int BEAT_W      = 4;

    function automatic int beats(input int bytes, input int lanes);
        return bytes / lanes;
    endfunction

endpackage

// File: rtl/sbox_LUT.sv
// Forward AES S-box for a single byte, purely combinational.
module sbox_LUT (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/sbox_share_ctrl.sv
// Arbitrates SubBytes (128-bit state) and SubWord (32-bit word) jobs onto a
// bank of LANES byte S-boxes, one job at a time, LANES bytes per beat.
module sbox_share_ctrl
    import sbox_share_ctrl_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_in,
    output logic [127:0] st_out,
    output logic         st_done,
    input  logic         kw_valid,
    output logic         kw_ready,
    input  logic [31:0]  kw_in,
    output logic [31:0]  kw_out,
    output logic         kw_done,
    output logic         busy
);

    localparam int ST_BEATS = beats(STATE_BYTES, LANES);
    localparam int KW_BEATS = beats(WORD_BYTES, LANES);
    localparam logic [BEAT_W-1:0] ST_LAST = BEAT_W'(ST_BEATS - 1);
    localparam logic [BEAT_W-1:0] KW_LAST = BEAT_W'(KW_BEATS - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
            $error("sbox_share_ctrl: LANES must be 1, 2 or 4");
        end
    endgenerate

    state_e              r_state;
    state_e              w_next_state;
    grant_e              r_last_grant;
    logic [BEAT_W-1:0]   r_beat;
    logic [127:0]        r_buf;
    logic [127:0]        r_st_out;
    logic [31:0]         r_kw_out;
    logic                r_st_done;
    logic                r_kw_done;

    logic                w_idle;
    logic                w_grant_st;
    logic                w_grant_kw;
    logic                w_st_acc;
    logic                w_kw_acc;
    logic                w_last_beat;
    logic [7:0]          w_buf_byte [STATE_BYTES];
    logic [BEAT_W-1:0]   w_idx      [LANES];
    logic [7:0]          w_lane_in  [LANES];
    logic [7:0]          w_lane_out [LANES];

    // A tie goes to whichever side was not granted last; a lone request always wins.
    assign w_idle     = (r_state == IDLE);
    assign w_grant_st = st_valid & (~kw_valid | (r_last_grant == GRANT_KW));
    assign w_grant_kw = kw_valid & (~st_valid | (r_last_grant == GRANT_ST));
    assign st_ready   = w_idle & ~rst & ~w_grant_kw;
    assign kw_ready   = w_idle & ~rst & ~w_grant_st;
    assign w_st_acc   = st_valid & st_ready;
    assign w_kw_acc   = kw_valid & kw_ready;
    assign w_last_beat = ((r_state == RUN_ST) && (r_beat == ST_LAST)) ||
                         ((r_state == RUN_KW) && (r_beat == KW_LAST));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment first guarantees no latch on paths that
    // leave the state unchanged.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_st_acc)      w_next_state = RUN_ST;
                else if (w_kw_acc) w_next_state = RUN_KW;
            end
            RUN_ST, RUN_KW: begin
                if (w_last_beat) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Lane l of beat j works on buffer byte j*LANES + l.
    always_comb begin
        for (int k = 0; k < STATE_BYTES; k++) begin
            w_buf_byte[k] = r_buf[127 - 8*k -: 8];
        end
        for (int l = 0; l < LANES; l++) begin
            w_idx[l]     = BEAT_W'(int'(r_beat) * LANES + l);
            w_lane_in[l] = w_buf_byte[w_idx[l]];
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            sbox_LUT u_sbox (
                .i_byte (w_lane_in[g]),
                .o_byte (w_lane_out[g])
            );
        end
    endgenerate

    // NOTE: the job buffer is pure datapath, always loaded before use, so it
    // carries no reset.
    always_ff @(posedge clk) begin
        if (w_st_acc) begin
            r_buf <= st_in;
        end else if (w_kw_acc) begin
            r_buf <= {kw_in, r_buf[95:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat       <= '0;
            r_last_grant <= GRANT_ST;
            r_st_out     <= '0;
            r_kw_out     <= '0;
            r_st_done    <= 1'b0;
            r_kw_done    <= 1'b0;
        end else begin
            r_st_done <= (r_state == RUN_ST) && w_last_beat;
            r_kw_done <= (r_state == RUN_KW) && w_last_beat;

            if (w_st_acc || w_kw_acc) begin
                r_beat       <= '0;
                r_last_grant <= w_st_acc ? GRANT_ST : GRANT_KW;
            end else if (!w_idle) begin
                r_beat <= r_beat + 1'b1;
            end

            // Byte k sits at bit offset 8*(15-k) in the state, 8*(3-k) in the word.
            for (int l = 0; l < LANES; l++) begin
                if (r_state == RUN_ST) begin
                    r_st_out[{~w_idx[l], 3'b000} +: 8] <= w_lane_out[l];
                end
                if (r_state == RUN_KW) begin
                    r_kw_out[{~w_idx[l][1:0], 3'b000} +: 8] <= w_lane_out[l];
                end
            end
        end
    end

    assign st_out  = r_st_out;
    assign kw_out  = r_kw_out;
    assign st_done = r_st_done;
    assign kw_done = r_kw_done;
    assign busy    = ~w_idle;

endmodule
